// File: rtl/im_loader_if.sv
// Instruction-memory loader bus: byte stream in, word writes out.
// Control, stream and memory-write signals travel together.
interface im_loader_if #(
   parameter int AW = 32
);
   logic          start;
   logic [AW-1:0] base_addr;
   logic [15:0]   word_count;
   logic          abort;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_data;
   logic          busy;
   logic          done;
   logic          err;

   modport master (
      output start, base_addr, word_count, abort,
      output in_data, in_valid,
      input  in_ready, wr_en, wr_addr, wr_data,
      input  busy, done, err
   );

   modport slave (
      input  start, base_addr, word_count, abort,
      input  in_data, in_valid,
      output in_ready, wr_en, wr_addr, wr_data,
      output busy, done, err
   );
endinterface

// File: rtl/im_loader.sv
// Loads instruction memory from a little-endian byte stream.
// Four bytes form one word; each word is written in its own cycle.
module im_loader #(
   parameter int NMEM = 128,
   parameter int AW   = 32
) (
   input logic       clk,
   input logic       rst_n,
   im_loader_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      WRITE,
      DONE
   } state_t;

   state_t        state;
   logic [AW-1:0] base;
   logic [15:0]   cnt;
   logic [15:0]   widx;
   logic [1:0]    bcnt;
   logic [23:0]   word;
   logic          in_ready_q;
   logic          wr_en_q;
   logic [AW-1:0] wr_addr_q;
   logic [31:0]   wr_data_q;
   logic          busy_q;
   logic          done_q;
   logic          err_q;

   logic bad_cnt;
   logic take;
   logic last;

   assign bad_cnt = (bus.word_count == 16'd0) ||
                    (32'(bus.word_count) > 32'(NMEM));
   assign take    = bus.in_valid && in_ready_q;
   assign last    = (widx == cnt - 16'd1);

   // An abort landing on the write cycle must kill the strobe at once.
   assign bus.wr_en    = wr_en_q && !bus.abort;
   assign bus.in_ready = in_ready_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;

   // Loader FSM; all outputs registered for the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         base       <= '0;
         cnt        <= '0;
         widx       <= '0;
         bcnt       <= '0;
         word       <= '0;
         in_ready_q <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         wr_en_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  busy_q <= 1'b1;
                  if (bad_cnt) begin
                     err_q  <= 1'b1;
                     done_q <= 1'b1;
                     state  <= DONE;
                  end else begin
                     base       <= {bus.base_addr[AW-1:2], 2'b00};
                     cnt        <= bus.word_count;
                     widx       <= '0;
                     bcnt       <= '0;
                     word       <= '0;
                     err_q      <= 1'b0;
                     in_ready_q <= 1'b1;
                     state      <= RECV;
                  end
               end
            end
            RECV: begin
               if (bus.abort) begin
                  bcnt       <= '0;
                  word       <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b0;
                  state      <= IDLE;
               end else if (take) begin
                  bcnt <= bcnt + 2'd1;
                  if (bcnt == 2'd3) begin
                     wr_data_q  <= {bus.in_data, word};
                     wr_addr_q  <= base + (AW'(widx) << 2);
                     wr_en_q    <= 1'b1;
                     in_ready_q <= 1'b0;
                     state      <= WRITE;
                  end else begin
                     word[{bcnt, 3'b000} +: 8] <= bus.in_data;
                  end
               end
            end
            WRITE: begin
               word <= '0;
               if (bus.abort) begin
                  bcnt   <= '0;
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end else begin
                  widx <= widx + 16'd1;
                  if (last) begin
                     done_q <= 1'b1;
                     state  <= DONE;
                  end else begin
                     in_ready_q <= 1'b1;
                     state      <= RECV;
                  end
               end
            end
            DONE: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader.
// Table vectors, random loads, abort and reset sequences.
module tb_im_loader;

   localparam int NMEM = 128;
   localparam int AW   = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   im_loader_if #(.AW(AW)) bus ();

   im_loader #(.NMEM(NMEM), .AW(AW)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [63:0] wlog [0:4095];
   int wn = 0;
   int dn = 0;
   int bn = 0;
   int vn = 0;

   // Observe writes, done pulses, busy cycles and ready misuse.
   always @(negedge clk) begin
      if (bus.wr_en) begin
         wlog[wn % 4096] <= {bus.wr_addr, bus.wr_data};
         wn <= wn + 1;
      end
      if (bus.done) dn <= dn + 1;
      if (bus.busy) bn <= bn + 1;
      if (bus.in_ready && (bus.wr_en || bus.done || !bus.busy))
         vn <= vn + 1;
   end

   typedef struct {
      logic [31:0] base;
      int          cnt;
      int          mode;
      int          abort_at;
      bit          fixed;
   } vec_t;

   logic [7:0] fixb [0:7] = '{8'h78, 8'h56, 8'h34, 8'h12,
                              8'hEF, 8'hBE, 8'hAD, 8'hDE};

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // One load, checked against the expected list of writes.
   task automatic run_case(input logic [31:0] base, input int cnt,
                           input int mode, input int abort_at,
                           input bit fixed, input string nm);
      logic [7:0]  bq[$];
      logic [31:0] ea, ed;
      int w0, d0, b0, v0, idx, cyc, nexp, budget, got;
      bit fin, aborted, rej;
      rej = (cnt == 0) || (cnt > NMEM);
      bq.delete();
      if (!rej)
         for (int k = 0; k < 4 * cnt; k++)
            bq.push_back(fixed ? fixb[k % 8] : 8'($urandom_range(0, 255)));
      w0 = wn; d0 = dn; b0 = bn; v0 = vn;
      bus.start      = 1'b1;
      bus.base_addr  = base;
      bus.word_count = 16'(cnt);
      @(posedge clk); #1;
      bus.start = 1'b0;
      idx = 0; cyc = 0; fin = 0; aborted = 0;
      budget = 20 * cnt + 60;
      while (!fin && cyc < budget) begin
         bit v, r;
         if (abort_at >= 0 && idx == abort_at && !aborted) begin
            bus.abort    = 1'b1;
            bus.in_valid = 1'b0;
            aborted      = 1;
            @(posedge clk); #1;
            bus.abort = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            fin = 1;
         end else begin
            v = (idx < bq.size()) &&
                (mode == 0 || (mode == 1 && cyc % 2 == 0) ||
                 (mode == 2 && $urandom_range(0, 1) == 1));
            bus.in_valid = v;
            bus.in_data  = (idx < bq.size()) ? bq[idx] : 8'h00;
            r = bus.in_ready;
            if (!rej && abort_at < 0 && cyc == 2) begin
               bus.start      = 1'b1;
               bus.base_addr  = 32'hDEAD_0000;
               bus.word_count = 16'd1;
            end else begin
               bus.start = 1'b0;
            end
            @(posedge clk); #1;
            if (v && r) idx++;
            cyc++;
            if (dn != d0) fin = 1;
         end
      end
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
      chk({nm, " finished"}, 64'(fin), 64'd1);
      if (mode == 0 && !rej && abort_at < 0)
         chk({nm, " cycles"}, 64'(cyc), 64'(5 * cnt + 1));
      repeat (2) @(posedge clk);
      #1;
      if (rej)
         nexp = 0;
      else if (abort_at < 0)
         nexp = cnt;
      else if (abort_at > 0 && abort_at % 4 == 0)
         nexp = abort_at / 4 - 1;
      else
         nexp = abort_at / 4;
      got = wn - w0;
      chk({nm, " nwrites"}, 64'(got), 64'(nexp));
      for (int k = 0; k < nexp && k < got; k++) begin
         ea = (base & 32'hFFFF_FFFC) + 32'(4 * k);
         ed = 32'(bq[4*k]) + (32'(bq[4*k+1]) << 8) +
              (32'(bq[4*k+2]) << 16) + (32'(bq[4*k+3]) << 24);
         chk({nm, " write"}, wlog[(w0 + k) % 4096], {ea, ed});
      end
      chk({nm, " done"}, 64'(dn - d0), (abort_at < 0) ? 64'd1 : 64'd0);
      chk({nm, " err"}, 64'(bus.err), 64'(rej));
      chk({nm, " busy"}, 64'(bus.busy), 64'd0);
      chk({nm, " ready"}, 64'(vn - v0), 64'd0);
      if (rej) chk({nm, " busycyc"}, 64'(bn - b0), 64'd1);
   endtask

   // Reset pulse in the middle of word 0.
   task automatic reset_mid_load();
      int w0, d0, idx, cyc;
      w0 = wn; d0 = dn;
      bus.start      = 1'b1;
      bus.base_addr  = 32'h200;
      bus.word_count = 16'd2;
      @(posedge clk); #1;
      bus.start = 1'b0;
      idx = 0; cyc = 0;
      while (idx < 2 && cyc < 20) begin
         bit r;
         bus.in_valid = 1'b1;
         bus.in_data  = 8'hA0 + 8'(idx);
         r = bus.in_ready;
         @(posedge clk); #1;
         if (r) idx++;
         cyc++;
      end
      chk("rst reached", 64'(idx), 64'd2);
      bus.in_data = 8'hA2;
      rst_n = 1'b0;
      #1;
      chk("rst flags",
          64'({bus.in_ready, bus.wr_en, bus.busy, bus.done, bus.err}),
          64'd0);
      chk("rst wr_addr", 64'(bus.wr_addr), 64'd0);
      chk("rst wr_data", 64'(bus.wr_data), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("rst nwrites", 64'(wn - w0), 64'd0);
      chk("rst done", 64'(dn - d0), 64'd0);
      chk("rst busy", 64'(bus.busy), 64'd0);
   endtask

   initial begin
      vec_t tab [10];
      tab[0] = '{32'h40, 2, 0, -1, 1};
      tab[1] = '{32'h40, 2, 1, -1, 1};
      tab[2] = '{32'h80, 0, 0, -1, 0};
      tab[3] = '{32'h80, NMEM + 1, 0, -1, 0};
      tab[4] = '{32'h103, 1, 0, -1, 0};
      tab[5] = '{32'h300, 3, 0, 6, 0};
      tab[6] = '{32'h500, 1, 2, -1, 0};
      tab[7] = '{32'h600, 2, 0, 4, 0};
      tab[8] = '{32'hFFFF_FFF8, NMEM, 0, -1, 0};
      tab[9] = '{32'h10, 3, 2, -1, 0};

      bus.start      = 1'b0;
      bus.base_addr  = '0;
      bus.word_count = '0;
      bus.abort      = 1'b0;
      bus.in_data    = '0;
      bus.in_valid   = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset flags",
          64'({bus.in_ready, bus.wr_en, bus.busy, bus.done, bus.err}),
          64'd0);
      chk("reset wr_addr", 64'(bus.wr_addr), 64'd0);
      chk("reset wr_data", 64'(bus.wr_data), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++)
         run_case(tab[i].base, tab[i].cnt, tab[i].mode,
                  tab[i].abort_at, tab[i].fixed, $sformatf("vec%0d", i));

      for (int i = 0; i < 15; i++) begin
         int c, ab;
         c  = $urandom_range(1, 5);
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4 * c - 1) : -1;
         run_case($urandom, c, $urandom_range(0, 2), ab, 0,
                  $sformatf("rnd%0d", i));
      end

      reset_mid_load();
      run_case(32'h700, 1, 0, -1, 0, "post-rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
